// File: rtl/recursion_pass_scheduler.sv
// Sequencer that time-multiplexes one shared fixed-latency complex MAC unit
// across N lookback-recursion channels. One pass per downsampled strobe:
// issue channels 0..N-1 back to back, track write-backs, pulse done.
module recursion_pass_scheduler #(
  parameter int unsigned N      = 4,
  parameter int unsigned PU_LAT = 2,
  parameter int unsigned DSR    = 12,
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic          valid_in,
  output logic          issue,
  output logic [CW-1:0] ch_sel,
  output logic          zero_state,
  output logic          wb_en,
  output logic [CW-1:0] wb_ch,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  // A full pass (issue + drain + done + return to idle) must fit in one sample period.
  localparam bit FitsInSample = (N + PU_LAT + 2) <= DSR;

  if (!FitsInSample) begin : g_bad_params
    $error("recursion_pass_scheduler: N + PU_LAT + 2 exceeds DSR");
  end

  localparam logic [CW-1:0] LastCh = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zs_q;
  logic          overrun_q;
  logic [PU_LAT-1:0] wb_vld_q;
  logic [CW-1:0]     wb_ch_q [PU_LAT];

  // State, channel counter, per-pass zero-state flag and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      zs_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Captured once at pass start so a mid-pass valid_in change is ignored.
      if (state_q == StIdle && strobe) zs_q <= !valid_in;
      if (state_q != StIdle && strobe) overrun_q <= 1'b1;
    end
  end

  // Write-back tracker: delays {issue, ch_sel} by exactly PU_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_q <= '0;
      for (int i = 0; i < int'(PU_LAT); i++) wb_ch_q[i] <= '0;
    end else begin
      wb_vld_q[0] <= issue;
      wb_ch_q[0]  <= ch_sel;
      for (int i = 1; i < int'(PU_LAT); i++) begin
        wb_vld_q[i] <= wb_vld_q[i-1];
        wb_ch_q[i]  <= wb_ch_q[i-1];
      end
    end
  end

  assign wb_en      = wb_vld_q[PU_LAT-1];
  assign wb_ch      = wb_ch_q[PU_LAT-1];
  assign zero_state = issue & zs_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

  // Next-state logic and Moore outputs of the pass sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    ch_sel  = '0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe) state_d = StIssue;
      end
      StIssue: begin
        issue  = 1'b1;
        ch_sel = cnt_q;
        if (cnt_q == LastCh) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        // The last channel's result is written this cycle; finish next cycle.
        if (wb_en && wb_ch == LastCh) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_recursion_pass_scheduler.sv
// Self-checking bench for recursion_pass_scheduler (N=4, PU_LAT=2, DSR=12).
// Expected outputs come from a pass-offset model: each output is a function
// of how many cycles have elapsed since the accepted strobe.
module tb_recursion_pass_scheduler;

  localparam int N   = 4;
  localparam int L   = 2;
  localparam int DSR = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic       valid_in;
  logic       issue;
  logic [1:0] ch_sel;
  logic       zero_state;
  logic       wb_en;
  logic [1:0] wb_ch;
  logic       busy;
  logic       done;
  logic       overrun;

  recursion_pass_scheduler #(
    .N      (N),
    .PU_LAT (L),
    .DSR    (DSR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .strobe     (strobe),
    .valid_in   (valid_in),
    .issue      (issue),
    .ch_sel     (ch_sel),
    .zero_state (zero_state),
    .wb_en      (wb_en),
    .wb_ch      (wb_ch),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  int pass_start = -1;
  bit m_zs       = 1'b0;
  bit m_ovr      = 1'b0;

  // Packed output vector: issue ch[2] zs wb_en wb_ch[2] busy done ovr
  function automatic logic [9:0] pk(bit i, int c, bit z, bit w, int wc, bit b, bit d, bit o);
    logic [1:0] c2;
    logic [1:0] wc2;
    c2  = c[1:0];
    wc2 = wc[1:0];
    return {i, c2, z, w, wc2, b, d, o};
  endfunction

  function automatic logic [9:0] model_exp();
    int  d;
    bit  i, w;
    d = (pass_start >= 0) ? (cyc - pass_start) : -1000;
    i = (d >= 1) && (d <= N);
    w = (d >= 1 + L) && (d <= N + L);
    return pk(i, i ? d - 1 : 0, i ? m_zs : 1'b0, w, w ? d - 1 - L : 0,
              (d >= 1) && (d <= N + L + 1), d == N + L + 1, m_ovr);
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b required=%b (issue ch zs wb_en wb_ch busy done ovr)",
               name, cyc, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // One cycle: compare current outputs with the model, apply inputs, advance the model.
  task automatic step(input bit r, input bit s, input bit v, output logic [9:0] got);
    int  d;
    bit  idle;
    @(negedge clk);
    got = {issue, ch_sel, zero_state, wb_en, wb_ch, busy, done, overrun};
    check("model", got, model_exp());
    rst      = r;
    strobe   = s;
    valid_in = v;
    d    = (pass_start >= 0) ? (cyc - pass_start) : -1000;
    idle = (pass_start < 0) || (d >= N + L + 2);
    if (r) begin
      pass_start = -1;
      m_ovr      = 1'b0;
      m_zs       = 1'b0;
    end else if (s) begin
      if (idle) begin
        pass_start = cyc;
        m_zs       = !v;
      end else begin
        m_ovr = 1'b1;
      end
    end
    cyc++;
  endtask

  typedef struct {
    bit         s;
    bit         v;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl [9];
  logic [9:0] got;
  int         n_done, n_wb;

  initial begin
    // Hand-written single pass: strobe at row 0.
    tbl[0] = '{1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b0, 1'b1, pk(1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[2] = '{1'b0, 1'b1, pk(1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[3] = '{1'b0, 1'b1, pk(1, 2, 0, 1, 0, 1, 0, 0)};
    tbl[4] = '{1'b0, 1'b1, pk(1, 3, 0, 1, 1, 1, 0, 0)};
    tbl[5] = '{1'b0, 1'b1, pk(0, 0, 0, 1, 2, 1, 0, 0)};
    tbl[6] = '{1'b0, 1'b1, pk(0, 0, 0, 1, 3, 1, 0, 0)};
    tbl[7] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 1, 0)};
    tbl[8] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1; strobe = 1'b0; valid_in = 1'b1;
    repeat (3) @(posedge clk);
    // Reset state and idle cycles.
    for (int k = 0; k < 4; k++) step(0, 0, 1, got);

    // Basic pass from the table.
    for (int i = 0; i < 9; i++) begin
      step(0, tbl[i].s, tbl[i].v, got);
      check("table", got, tbl[i].exp);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 1, got);

    // valid_in low at strobe, raised mid-pass: zero_state held for whole pass.
    step(0, 1, 0, got);
    step(0, 0, 0, got);
    for (int k = 0; k < 10; k++) step(0, 0, 1, got);
    step(0, 1, 1, got);
    for (int k = 0; k < 11; k++) step(0, 0, 1, got);

    // 20 back-to-back passes at the sample rate.
    n_done = 0; n_wb = 0;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < DSR; k++) begin
        step(0, k == 0, 1, got);
        if (got[1]) begin
          n_done++;
          check_int("done_offset", k, N + L + 1);
        end
        if (got[5]) n_wb++;
      end
    end
    check_int("done_count", n_done, 20);
    check_int("wb_count", n_wb, 80);
    check_int("overrun_after_20", int'(overrun), 0);

    // Strobe during DRAIN: ignored, overrun set and held across a later pass.
    step(0, 1, 1, got);
    for (int k = 1; k < 12; k++) step(0, k == 5, 1, got);
    check_int("overrun_set", int'(overrun), 1);
    for (int k = 0; k < 12; k++) step(0, k == 0, 1, got);
    check_int("overrun_held", int'(overrun), 1);

    // Reset mid-ISSUE drops in-flight write-backs; later pass is clean.
    step(0, 1, 1, got);
    step(0, 0, 1, got);
    step(0, 0, 1, got);
    step(1, 0, 1, got);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, got);
      check("after_rst", got, 10'b0);
    end
    for (int k = 0; k < 12; k++) step(0, k == 0, 1, got);

    // Strobe coincident with reset: no pass, overrun stays 0.
    step(0, 1, 1, got);
    for (int k = 0; k < 6; k++) step(0, 1, 1, got);
    step(1, 1, 1, got);
    step(0, 0, 1, got);
    check("rst_strobe", got, 10'b0);
    step(0, 0, 1, got);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0), 1'($urandom), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recursion_pass_scheduler.md
Name: recursion_pass_scheduler

Overview:
- Time-multiplexes one shared complex fixed-point multiply-add unit (CFixPU-style, fixed pipeline latency) across the N lookback-recursion channels of the hybrid filter.
- On each downsampled sample strobe it runs one pass: issues channels 0..N-1 on consecutive cycles, then tracks their write-backs and signals pass completion.
- Runs on the fast clock. Replaces N parallel recursion PUs with one PU plus this sequencer.

Parameters:
- N, 4, number of recursion channels served per pass (>=1).
- PU_LAT, 2, pipeline latency of the shared PU in cycles, issue to result (>=1).
- DSR, 12, fast-clock cycles per downsampled sample. Design constraint: N+PU_LAT+2 <= DSR.

Ports:
- clk  in  1  fast clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- strobe  in  1  one-cycle pulse marking a new downsampled sample (ClkDiv count wrap).
- valid_in  in  1  recursion state valid (validCompute). Low means previous state is garbage.
- issue  out  1  operands for channel ch_sel are presented to the PU this cycle.
- ch_sel  out  $clog2(N) (min 1)  channel being issued; selects operand/coefficient mux.
- zero_state  out  1  PU uses zero instead of stored previous state for this pass.
- wb_en  out  1  PU result valid; write it into state register wb_ch.
- wb_ch  out  $clog2(N) (min 1)  channel of current write-back.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle pulse: all N results of the pass are written.
- overrun  out  1  sticky error: a strobe arrived while not IDLE.

Behaviour:
- Reset (synchronous, priority over all): state=IDLE, channel counter=0, write-back pipeline cleared. All outputs 0, including sticky overrun. In-flight results are dropped; no wb_en is asserted after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: strobe=1 -> ISSUE next cycle. Sample zero_state_reg <= !valid_in on the same edge and hold it for the whole pass.
- ISSUE: issue=1, ch_sel=counter, counter increments each cycle. After issuing ch N-1, go to DRAIN and reset counter to 0. Lasts exactly N cycles.
- DRAIN: issue=0. Leave for DONE on the cycle after the wb_en for ch N-1.
- DONE: done=1 for one cycle, then IDLE.
- Write-back tracking: a PU_LAT-deep shift register of {valid, ch}. wb_en/wb_ch equal the issue/ch_sel values from exactly PU_LAT cycles earlier. wb_en is registered-aligned with the PU result.
- zero_state: driven from zero_state_reg while issue=1, otherwise 0.
- Timing from a strobe at cycle t:
  - issue at t+1..t+N, ch 0..N-1
  - wb_en at t+1+PU_LAT..t+N+PU_LAT
  - done at t+N+PU_LAT+1
  - busy at t+1..t+N+PU_LAT+1
  - IDLE again at t+N+PU_LAT+2
- Strobe in ISSUE, DRAIN or DONE: strobe is ignored (no restart, no queueing) and overrun is set to 1. overrun stays 1 until rst.
- Strobe in the same cycle as rst: reset wins and overrun stays 0.
- valid_in changing mid-pass has no effect on the current pass.
- N=1: ISSUE lasts one cycle. ch_sel and wb_ch are constant 0.

Test Plan:
- N=4, PU_LAT=2, valid_in=1, strobe at cycle 10 -> issue 11–14 with ch_sel 0,1,2,3; wb_en 13–16 with wb_ch 0,1,2,3; done only at 17; busy 11–17; zero_state 0 throughout.
- valid_in=0 at strobe cycle 10, raised to 1 at cycle 12 -> zero_state=1 during cycles 11–14 (whole pass). Next pass, with valid_in=1 at its strobe -> zero_state=0.
- Strobes every 12 cycles for 20 passes -> 20 done pulses, each exactly 7 cycles after its strobe; 80 wb_en total; overrun stays 0.
- Second strobe at cycle 15 (DRAIN) -> ignored; pass still ends with done at 17; overrun=1 from cycle 16 and held. Next strobe at 22 runs normally; overrun still 1.
- rst=1 at cycle 13, mid-ISSUE -> cycle 14 onward: all outputs 0, no wb_en for ch 0/1 issued earlier. Strobe at 20 -> clean pass, done at 27.
- Strobe and rst both high at cycle 10 -> no pass starts; overrun=0; busy=0 at 11.
